// File: rtl/sd_emmc_axi_wr_beat_master.sv
// Single-beat AXI4 write master behind the eMMC DMA (card -> memory path).
// One 32-bit AXI write per DMA word, with sticky error flags and a beat counter.
module sd_emmc_axi_wr_beat_master #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic              addr_write_valid,
    output logic              addr_write_ready,
    input  logic              data_write_valid,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic              w_last,
    output logic              next_data_word,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [7:0]        m_axi_awlen,
    output logic [2:0]        m_axi_awsize,
    output logic [1:0]        m_axi_awburst,
    output logic [3:0]        m_axi_awcache,
    output logic [2:0]        m_axi_awprot,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wlast,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    input  logic              err_clr,
    input  logic              cnt_clr,
    output logic              resp_err,
    output logic              timeout_err,
    output logic              align_err,
    output logic [15:0]       beats_done,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DATA,
        S_ISSUE,
        S_WAIT_B,
        S_DONE
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t              state_q;
    logic [ADDR_W-1:0]   awaddr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                awvalid_q, wvalid_q, bready_q;
    logic                aw_done_q, w_done_q;
    logic [15:0]         to_cnt_q;
    logic                awr_q, ndw_q, busy_q;
    logic                resp_err_q, timeout_err_q, align_err_q;
    logic [15:0]         beats_q;

    logic aw_hs, w_hs;
    assign aw_hs = awvalid_q & m_axi_awready;
    assign w_hs  = wvalid_q & m_axi_wready;

    // DMA last flag carries no meaning for single-beat bursts.
    logic unused_w_last;
    assign unused_w_last = w_last;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            to_cnt_q      <= '0;
            awr_q         <= 1'b0;
            ndw_q         <= 1'b0;
            busy_q        <= 1'b0;
            resp_err_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            align_err_q   <= 1'b0;
            beats_q       <= '0;
        end else begin
            awr_q <= 1'b0;
            ndw_q <= 1'b0;
            // Clear first so a same-cycle set below takes priority.
            if (err_clr) begin
                resp_err_q    <= 1'b0;
                timeout_err_q <= 1'b0;
                align_err_q   <= 1'b0;
            end
            if (state_q == S_ISSUE || state_q == S_WAIT_B) begin
                if (to_cnt_q == TO_LAST) timeout_err_q <= 1'b1;
                if (to_cnt_q != 16'hFFFF) to_cnt_q <= to_cnt_q + 16'd1;
            end
            case (state_q)
                S_IDLE: begin
                    if (addr_write_valid && !data_write_valid) begin
                        awaddr_q <= {write_addr[ADDR_W-1:2], 2'b00};
                        if (write_addr[1:0] != 2'b00) align_err_q <= 1'b1;
                        awr_q    <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= S_WAIT_DATA;
                    end
                end
                S_WAIT_DATA: begin
                    if (data_write_valid) begin
                        wdata_q   <= wdata_in;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        to_cnt_q  <= '0;
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WAIT_B;
                    end
                end
                S_WAIT_B: begin
                    if (m_axi_bvalid) begin
                        bready_q <= 1'b0;
                        if (m_axi_bresp[1]) resp_err_q <= 1'b1;
                        beats_q  <= beats_q + 16'd1;
                        ndw_q    <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
            if (cnt_clr) beats_q <= '0;
        end
    end

    assign addr_write_ready = awr_q;
    assign next_data_word   = ndw_q;
    assign m_axi_awaddr     = awaddr_q;
    assign m_axi_awvalid    = awvalid_q;
    assign m_axi_awlen      = 8'd0;
    assign m_axi_awsize     = 3'b010;
    assign m_axi_awburst    = 2'b01;
    assign m_axi_awcache    = 4'b0011;
    assign m_axi_awprot     = 3'b000;
    assign m_axi_wdata      = wdata_q;
    assign m_axi_wstrb      = 4'hF;
    assign m_axi_wlast      = 1'b1;
    assign m_axi_wvalid     = wvalid_q;
    assign m_axi_bready     = bready_q;
    assign resp_err         = resp_err_q;
    assign timeout_err      = timeout_err_q;
    assign align_err        = align_err_q;
    assign beats_done       = beats_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_sd_emmc_axi_wr_beat_master.sv
// Scoreboard bench for sd_emmc_axi_wr_beat_master: DMA/slave models push
// expected AW/W/beat records, a negedge monitor pops and compares them.
module tb_sd_emmc_axi_wr_beat_master;
    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] write_addr = '0;
    logic        addr_write_valid = 1'b0;
    logic        addr_write_ready;
    logic        data_write_valid = 1'b0;
    logic [31:0] wdata_in = '0;
    logic        w_last = 1'b0;
    logic        next_data_word;
    logic [31:0] m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic [3:0]  m_axi_awcache;
    logic [2:0]  m_axi_awprot;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic [1:0]  m_axi_bresp = '0;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;
    logic        err_clr, cnt_clr;
    logic        tb_err_clr = 1'b0, sb_err_clr = 1'b0;
    logic        tb_cnt_clr = 1'b0, sb_cnt_clr = 1'b0;
    logic        resp_err, timeout_err, align_err, busy;
    logic [15:0] beats_done;

    assign err_clr = tb_err_clr | sb_err_clr;
    assign cnt_clr = tb_cnt_clr | sb_cnt_clr;

    sd_emmc_axi_wr_beat_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
        .clock(clock), .reset(reset),
        .write_addr(write_addr), .addr_write_valid(addr_write_valid),
        .addr_write_ready(addr_write_ready), .data_write_valid(data_write_valid),
        .wdata_in(wdata_in), .w_last(w_last), .next_data_word(next_data_word),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .err_clr(err_clr), .cnt_clr(cnt_clr),
        .resp_err(resp_err), .timeout_err(timeout_err), .align_err(align_err),
        .beats_done(beats_done), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct { logic [31:0] val; int hold; } ch_exp_t;
    typedef struct { logic [15:0] beats; logic resp; logic align; logic to; } beat_exp_t;
    ch_exp_t   exp_aw[$];
    ch_exp_t   exp_w[$];
    beat_exp_t exp_beat[$];

    int checks = 0;
    int errors = 0;

    // Reference model of the sticky flags and beat counter.
    logic [15:0] m_beats = '0;
    logic        m_resp = 1'b0, m_align = 1'b0, m_to = 1'b0;

    // Slave behaviour for the current beat.
    int         aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [1:0] cfg_bresp = 2'b00;
    logic       cfg_clr_b = 1'b0, cfg_cntclr_b = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin : aw_slave
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clock); #1;
            if (m_axi_awvalid) begin m_axi_awready = (cnt >= aw_dly); cnt++; end
            else begin m_axi_awready = 1'b0; cnt = 0; end
        end
    end

    initial begin : w_slave
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clock); #1;
            if (m_axi_wvalid) begin m_axi_wready = (cnt >= w_dly); cnt++; end
            else begin m_axi_wready = 1'b0; cnt = 0; end
        end
    end

    initial begin : b_slave
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clock); #1;
            if (m_axi_bready) begin
                if (cnt >= b_dly) begin
                    m_axi_bvalid = 1'b1;
                    m_axi_bresp  = cfg_bresp;
                    sb_err_clr   = cfg_clr_b;
                    sb_cnt_clr   = cfg_cntclr_b;
                end
                cnt++;
            end else begin
                m_axi_bvalid = 1'b0;
                m_axi_bresp  = 2'b00;
                sb_err_clr   = 1'b0;
                sb_cnt_clr   = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin : monitor
        int aw_hold, w_hold, idx;
        logic bready_prev, issue_prev, to_prev;
        ch_exp_t e;
        beat_exp_t b;
        aw_hold = 0; w_hold = 0; idx = 0;
        bready_prev = 1'b0; issue_prev = 1'b0; to_prev = 1'b0;
        forever begin
            @(negedge clock);
            aw_hold = m_axi_awvalid ? aw_hold + 1 : 0;
            w_hold  = m_axi_wvalid ? w_hold + 1 : 0;
            if (m_axi_awvalid && m_axi_awready) begin
                if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
                else begin
                    e = exp_aw.pop_front();
                    chk("awaddr", m_axi_awaddr, e.val);
                    chk("aw_hold", aw_hold, e.hold);
                end
            end
            if (m_axi_wvalid && m_axi_wready) begin
                if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
                else begin
                    e = exp_w.pop_front();
                    chk("wdata", m_axi_wdata, e.val);
                    chk("w_hold", w_hold, e.hold);
                end
            end
            if (m_axi_bready && !bready_prev)
                chk("bready_before_hs", {m_axi_awvalid, m_axi_wvalid}, 0);
            if ((m_axi_awvalid || m_axi_wvalid) && !issue_prev && !bready_prev) idx = 1;
            else if (busy) idx++;
            if (timeout_err && !to_prev) chk("timeout_cycle", idx - 1, TO);
            if (next_data_word) begin
                if (exp_beat.size() == 0) chk("beat_unexpected", 1, 0);
                else begin
                    b = exp_beat.pop_front();
                    chk("beats_done", beats_done, b.beats);
                    chk("resp_err", resp_err, b.resp);
                    chk("align_err", align_err, b.align);
                    chk("timeout_err", timeout_err, b.to);
                end
            end
            bready_prev = m_axi_bready;
            issue_prev  = m_axi_awvalid || m_axi_wvalid;
            to_prev     = timeout_err;
        end
    end

    task automatic do_beat(input logic [31:0] a, input logic [31:0] d, input int awd,
                           input int wd, input int bd, input logic [1:0] rsp,
                           input logic clrb, input logic cntb, input logic guard,
                           output int lat);
        int t;
        logic ok;
        aw_dly = awd; w_dly = wd; b_dly = bd;
        cfg_bresp = rsp; cfg_clr_b = clrb; cfg_cntclr_b = cntb;
        t = ((awd > wd) ? awd : wd) + bd + 2;
        if (a[1:0] != 2'b00) m_align = 1'b1;
        if (t >= TO) m_to = 1'b1;
        if (rsp[1]) m_resp = 1'b1;
        if (clrb) begin m_align = 1'b0; m_to = 1'b0; m_resp = rsp[1]; end
        m_beats = cntb ? 16'd0 : m_beats + 16'd1;
        exp_aw.push_back('{val: {a[31:2], 2'b00}, hold: awd + 1});
        exp_w.push_back('{val: d, hold: wd + 1});
        exp_beat.push_back('{beats: m_beats, resp: m_resp, align: m_align, to: m_to});
        write_addr = a;
        w_last = 1'b1;
        if (guard) begin
            data_write_valid = 1'b1;
            addr_write_valid = 1'b1;
            repeat (3) begin
                @(posedge clock); #1;
                chk("guard_ready", addr_write_ready, 0);
                chk("guard_busy", busy, 0);
            end
            data_write_valid = 1'b0;
        end
        addr_write_valid = 1'b1;
        lat = 1;
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(posedge clock); #1; lat++;
            if (addr_write_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("addr_ready_wait", 0, 1);
        addr_write_valid = 1'b0;
        data_write_valid = 1'b1;
        wdata_in = d;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clock); #1; lat++;
            if (next_data_word) begin ok = 1'b1; break; end
        end
        if (!ok) chk("ndw_wait", 0, 1);
        @(posedge clock); #1;
        data_write_valid = 1'b0;
    endtask

    task automatic pulse_err_clr();
        tb_err_clr = 1'b1;
        @(posedge clock); #1;
        tb_err_clr = 1'b0;
        m_resp = 1'b0; m_align = 1'b0; m_to = 1'b0;
        chk("err_clr_flags", {resp_err, align_err, timeout_err}, 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat;
        logic ok;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_handshake", {addr_write_ready, next_data_word, m_axi_awvalid,
                              m_axi_wvalid, m_axi_bready, busy}, 0);
        chk("rst_flags", {resp_err, timeout_err, align_err}, 0);
        chk("rst_beats", beats_done, 0);
        chk("rst_awaddr", m_axi_awaddr, 0);
        chk("rst_wdata", m_axi_wdata, 0);
        chk("const_aw", {m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_awprot},
            {8'd0, 3'b010, 2'b01, 4'b0011, 3'b000});
        chk("const_w", {m_axi_wstrb, m_axi_wlast}, {4'hF, 1'b1});
        reset = 1'b1;
        @(posedge clock); #1;

        // Basic beat, minimum latency.
        do_beat(32'h1000_0040, 32'hDEAD_BEEF, 0, 0, 0, 2'b00, 0, 0, 0, lat);
        chk("basic_latency", lat, 5);
        chk("basic_beats", beats_done, 1);

        // Channel skew both ways, then a same-cycle completion after a stall.
        do_beat(32'h1000_0044, 32'h1111_2222, 3, 0, 0, 2'b00, 0, 0, 0, lat);
        do_beat(32'h1000_0048, 32'h3333_4444, 0, 3, 0, 2'b00, 0, 0, 0, lat);
        do_beat(32'h1000_004C, 32'h5555_6666, 2, 2, 1, 2'b00, 0, 0, 0, lat);

        // Error responses and clearing.
        do_beat(32'h1000_0050, 32'hCAFE_0001, 0, 0, 0, 2'b10, 0, 0, 0, lat);
        pulse_err_clr();
        do_beat(32'h1000_0054, 32'hCAFE_0002, 0, 0, 0, 2'b11, 1, 0, 0, lat);
        pulse_err_clr();
        do_beat(32'h1000_0058, 32'hCAFE_0003, 0, 0, 0, 2'b01, 0, 0, 0, lat);

        // Timeout boundary: 15 cycles in ISSUE+WAIT_B stay clean, 16 set the flag.
        do_beat(32'h1000_0060, 32'h0000_000F, 0, 0, 13, 2'b00, 0, 0, 0, lat);
        do_beat(32'h1000_0064, 32'h0000_0010, 0, 0, 14, 2'b00, 0, 0, 0, lat);
        pulse_err_clr();
        do_beat(32'h1000_0068, 32'h0000_0028, 0, 0, 40, 2'b00, 0, 0, 0, lat);
        chk("timeout_latency", lat, 45);
        pulse_err_clr();

        // Misaligned address, then the re-arm guard while data_write_valid lingers.
        do_beat(32'h0000_2003, 32'hA1A2_A3A4, 0, 0, 0, 2'b00, 0, 0, 0, lat);
        do_beat(32'h0000_2004, 32'hB1B2_B3B4, 0, 0, 0, 2'b00, 0, 0, 1, lat);
        pulse_err_clr();

        // Counter clear coincident with an increment.
        do_beat(32'h0000_2008, 32'hC1C2_C3C4, 0, 0, 0, 2'b00, 0, 1, 0, lat);
        chk("cnt_clr_win", beats_done, 0);

        // 128 back-to-back beats.
        for (int i = 0; i < 128; i++)
            do_beat(32'h3000_0000 + 32'(i) * 32'd4, 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000,
                    0, 0, 0, 2'b00, 0, 0, 0, lat);
        chk("block_beats", beats_done, 128);

        // Reset in the middle of a stalled ISSUE.
        aw_dly = 10; w_dly = 10; b_dly = 0;
        write_addr = 32'h4000_0000;
        addr_write_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(posedge clock); #1;
            if (addr_write_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("rst_test_ready_wait", 0, 1);
        addr_write_valid = 1'b0;
        data_write_valid = 1'b1;
        wdata_in = 32'h7777_8888;
        repeat (2) begin @(posedge clock); #1; end
        chk("pre_reset_valids", {m_axi_awvalid, m_axi_wvalid, busy}, 3'b111);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy}, 0);
        chk("midrst_beats", beats_done, 0);
        chk("midrst_addr_data", {m_axi_awaddr, m_axi_wdata}, 0);
        chk("midrst_flags", {resp_err, timeout_err, align_err, addr_write_ready, next_data_word}, 0);
        data_write_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        m_beats = '0; m_resp = 1'b0; m_align = 1'b0; m_to = 1'b0;
        @(posedge clock); #1;
        do_beat(32'h5000_0010, 32'h0BAD_F00D, 0, 0, 0, 2'b00, 0, 0, 0, lat);
        chk("post_reset_latency", lat, 5);
        chk("post_reset_beats", beats_done, 1);

        repeat (3) @(posedge clock);
        chk("queues_drained", exp_aw.size() + exp_w.size() + exp_beat.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
